// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: E-stage bundle between the pipeline and the multiply/divide unit.
//   md_op   : E-stage op (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none)
//   src_a   : forwarded rs value
//   src_b   : forwarded rt value
//   start   : op 1..4 presented while the unit is idle
//   busy    : registered, high while the countdown is running
//   md_busy : start | busy, feeds the hazard/stall unit
//   hi, lo  : architectural HI/LO registers
interface mult_div_unit_if;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        start;
  logic        busy;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, src_a, src_b,
    input  start, busy, md_busy, hi, lo
  );

  modport slave (
    input  md_op, src_a, src_b,
    output start, busy, md_busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit for the E stage of a 5-stage MIPS
// pipeline. Owns HI/LO and executes mult/multu/div/divu/mthi/mtlo.
// The full result is computed in the start cycle and parked in temp registers; a
// down-counter models the multi-cycle latency and commits temp into HI/LO on its
// final edge.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   md    : mult_div_unit_if.slave (md_op, src_a, src_b in; start, busy, md_busy, hi, lo out)
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   md
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_NOP7  = 3'd7
  } md_op_e;

  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_dz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_temp_hi;
  logic [31:0] r_temp_lo;

  md_op_e      w_op;
  logic        w_idle;
  logic        w_is_md;
  logic        w_start;
  logic [3:0]  w_cnt_nxt;
  logic [63:0] w_res;

  // Signed 32x32 -> 64 product; operands are sign-extended before multiplying.
  function automatic logic [63:0] f_mul_s(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  function automatic logic [63:0] f_mul_u(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}. Quotient truncates toward zero, remainder takes
  // the dividend's sign. The one overflowing case is pinned explicitly, and a zero
  // divisor yields 0 (never committed) to keep X out of the temp registers.
  function automatic logic [63:0] f_div_s(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'sd0) return 64'd0;
    if (a == 32'sh8000_0000 && b == -32'sd1) return {32'h0000_0000, 32'h8000_0000};
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  always_comb begin
    w_op      = md_op_e'(md.md_op);
    w_idle    = (r_cnt == 4'd0);
    w_is_md   = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                (w_op == OP_DIV)  || (w_op == OP_DIVU);
    w_start   = w_is_md && w_idle;
    w_res     = 64'd0;
    w_cnt_nxt = r_cnt;
    case (w_op)
      OP_MULT:  w_res = f_mul_s(md.src_a, md.src_b);
      OP_MULTU: w_res = f_mul_u(md.src_a, md.src_b);
      OP_DIV:   w_res = f_div_s(md.src_a, md.src_b);
      OP_DIVU:  w_res = f_div_u(md.src_a, md.src_b);
      default:  w_res = 64'd0;
    endcase
    if (w_start)
      w_cnt_nxt = (w_op == OP_MULT || w_op == OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    else if (!w_idle)
      w_cnt_nxt = r_cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_busy    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_temp_hi <= 32'd0;
      r_temp_lo <= 32'd0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != 4'd0);
      if (w_start) begin
        r_temp_hi <= w_res[63:32];
        r_temp_lo <= w_res[31:0];
        r_dz      <= (w_op == OP_DIV || w_op == OP_DIVU) && (md.src_b == 32'd0);
      end
      // Commit and mthi/mtlo are mutually exclusive: one needs r_cnt==1, the other idle.
      if (r_cnt == 4'd1) begin
        if (!r_dz) begin
          r_hi <= r_temp_hi;
          r_lo <= r_temp_lo;
        end
      end else if (w_idle && w_op == OP_MTHI) begin
        r_hi <= md.src_a;
      end else if (w_idle && w_op == OP_MTLO) begin
        r_lo <= md.src_a;
      end
    end
  end

  assign md.start   = w_start;
  assign md.busy    = r_busy;
  assign md.md_busy = w_start | r_busy;
  assign md.hi      = r_hi;
  assign md.lo      = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if md_if();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if.slave)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          ncyc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.md_op = op;
    md_if.src_a = a;
    md_if.src_b = b;
  endtask

  // Pops the oldest expected {hi,lo} and compares it with the DUT.
  task automatic sb_check(input string name);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_hi"}, {32'd0, md_if.hi}, {32'd0, e[63:32]});
      chk({name, "_lo"}, {32'd0, md_if.lo}, {32'd0, e[31:0]});
    end
  endtask

  // Issues one mult/div op at a negedge, counts busy cycles, then checks HI/LO.
  task automatic run_op(input string name, input vec_t v);
    int n;
    @(negedge clk);
    drive(v.op, v.a, v.b);
    #1;
    chk({name, "_start"}, {63'd0, md_if.start}, 64'd1);
    chk({name, "_md_busy"}, {63'd0, md_if.md_busy}, 64'd1);
    sb_q.push_back({v.exp_hi, v.exp_lo});
    @(negedge clk);
    drive(3'd0, 32'd0, 32'd0);
    n = 0;
    while (md_if.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'(v.ncyc));
    sb_check(name);
  endtask

  // mthi/mtlo on an idle unit: never starts, updates on the next edge.
  task automatic run_mt(input string name, input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    drive(op, a, 32'd0);
    #1;
    chk({name, "_start"}, {63'd0, md_if.start}, 64'd0);
    @(negedge clk);
    drive(3'd0, 32'd0, 32'd0);
    chk({name, "_busy"}, {63'd0, md_if.busy}, 64'd0);
    if (op == 3'd5) chk({name, "_hi"}, {32'd0, md_if.hi}, {32'd0, a});
    else            chk({name, "_lo"}, {32'd0, md_if.lo}, {32'd0, a});
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[4] = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[5] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};

    reset = 1'b1;
    drive(3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", {32'd0, md_if.hi}, 64'd0);
    chk("rst_lo", {32'd0, md_if.lo}, 64'd0);
    chk("rst_busy", {63'd0, md_if.busy}, 64'd0);
    chk("rst_md_busy", {63'd0, md_if.md_busy}, 64'd0);

    for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Divide by zero keeps HI/LO; ops presented while busy are ignored.
    run_mt("mthi11", 3'd5, 32'h11);
    run_mt("mtlo22", 3'd6, 32'h22);
    @(negedge clk);
    drive(3'd4, 32'd1234, 32'd0);
    #1;
    chk("dz_start", {63'd0, md_if.start}, 64'd1);
    sb_q.push_back({32'h11, 32'h22});
    @(negedge clk);
    n = 0;
    while (md_if.busy && n < 40) begin
      n++;
      case (n)
        1: drive(3'd6, 32'h55, 32'd0);
        2: begin
          drive(3'd1, 32'd3, 32'd3);
          #1;
          chk("busy_mult_start", {63'd0, md_if.start}, 64'd0);
          chk("busy_mult_md_busy", {63'd0, md_if.md_busy}, 64'd1);
        end
        default: drive(3'd0, 32'd0, 32'd0);
      endcase
      @(negedge clk);
    end
    chk("dz_busy_cycles", 64'(n), 64'd10);
    sb_check("dz");
    run_mt("mthiAA", 3'd5, 32'hAA);
    chk("mthiAA_lo_kept", {32'd0, md_if.lo}, 64'h22);

    // Reset in the middle of div 100/7 aborts it.
    @(negedge clk);
    drive(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    drive(3'd0, 32'd0, 32'd0);
    repeat (7) @(negedge clk);
    chk("abort_pre_busy", {63'd0, md_if.busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'd0, md_if.busy}, 64'd0);
    chk("abort_hi", {32'd0, md_if.hi}, 64'd0);
    chk("abort_lo", {32'd0, md_if.lo}, 64'd0);
    repeat (15) @(negedge clk);
    chk("abort_late_hi", {32'd0, md_if.hi}, 64'd0);
    chk("abort_late_lo", {32'd0, md_if.lo}, 64'd0);
    chk("abort_late_md_busy", {63'd0, md_if.md_busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo.
- Drives `md_busy` to the hazard/stall unit, which holds D and clears E while a D-stage mfhi/mflo/MD instruction sees `md_busy=1`.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15).
- DIV_CYCLES, 10, busy cycles after a div/divu start (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
- src_a  input  32  forwarded rs value (E stage).
- src_b  input  32  forwarded rt value (E stage).
- start  output  1  combinational; 1 when md_op is 1..4 and the unit is idle.
- busy  output  1  registered; 1 while the cycle counter is nonzero.
- md_busy  output  1  combinational `start | busy`; this is the hazard unit's MDbusy input.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset:
  - hi=0, lo=0, counter=0, temp_hi=0, temp_lo=0, busy=0.
  - Reset overrides any op present in the same cycle.
  - Reset mid-operation aborts the operation; its result is never committed.
- Idle means counter==0.
- Start, on an edge with an idle unit and md_op in 1..4:
  - temp_hi/temp_lo load the full result.
  - counter loads MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
- Countdown, on each edge with counter>0:
  - counter decrements by 1.
  - On the edge where counter==1: hi<=temp_hi and lo<=temp_lo.
- Resulting timing: busy is high for exactly N cycles, starting the cycle after start. New hi/lo are visible the first cycle busy is low again.
- Arithmetic:
  - mult: signed 32x32 to 64-bit; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 to 64-bit.
  - div: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend. 0x80000000/-1 gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (src_b==0) still runs the full DIV_CYCLES busy period, but hi/lo are left unchanged at commit.
- mthi/mtlo:
  - Idle unit: hi (or lo) <= src_a on the next edge; busy is not raised.
  - Busy unit: the op is ignored.
- Start while busy: ignored. start=0 in that case, the counter keeps running and temp registers hold. The hazard unit prevents this case; RTL must still be safe.
- md_op 0 or 7: no state change other than the countdown.
- Flush: a flushed E stage presents md_op=0. An operation already started is not cancelled by later bubbles.
- Back-to-back ops:
  - A new start is accepted on the first idle edge.
  - It may coincide with the commit edge of the previous op only if counter was 1 then. It cannot, because busy was high that cycle; the second op starts one cycle after busy falls.
- Commit priority on one edge: reset > countdown commit > mthi/mtlo. mthi/mtlo cannot coincide with a commit, since mthi/mtlo is ignored while busy.
- Outputs hi/lo are direct register outputs, with no bypass of temp values.

Test Plan:
- reset=1 for 2 cycles, then md_op=0 -> hi=0, lo=0, busy=0, md_busy=0.
- mult with src_a=0xFFFFFFFD (-3), src_b=5 -> md_busy=1 in the start cycle; busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu with src_a=0xFFFFFFFF, src_b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- div with src_a=0xFFFFFFF9 (-7), src_b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu by zero with hi=0x11, lo=0x22:
  - busy runs 10 cycles; hi=0x11, lo=0x22 unchanged.
  - In the same run: mtlo 0x55 issued during busy is ignored; after idle, mthi 0xAA gives hi=0xAA on the next edge with busy=0.
- Start div 100/7, assert reset when counter==3 -> next edge counter=0, busy=0, hi=lo=0. No later commit of 14/2.
